self_link_width_splitter: RTL and testbench
===========================================

Name: self_link_width_splitter

Overview:
- Upstream stage of the SELF single-stage elastic buffer.
- Accepts one wide word per SELF transfer and emits it as Ratio narrow beats, LS slice first, on a SELF output link.
- A per-word beat count allows short final words. dataOutLast marks the final beat of each word.
- Sustains one narrow beat per cycle, including across word boundaries.

Parameters:
- DataOutWidth, 16, width of each output beat.
- Ratio, 4, maximum beats per input word; integer >= 2, power of two not required.
- DataInWidth, DataOutWidth*Ratio, input word width; derived, not to be overridden.
- CountWidth, clog2(Ratio), width of dataInBeats and the internal beat counter.

Ports:
- clk  input  1  rising-edge clock.
- srst  input  1  synchronous reset, active-low (0 = reset).
- dataIn  input  DataInWidth  wide word.
- dataInBeats  input  CountWidth  number of beats minus one for this word.
- dataInValid  input  1  upstream valid.
- dataInStop  output  1  upstream stop.
- dataOut  output  DataOutWidth  current beat.
- dataOutLast  output  1  high on the final beat of a word.
- dataOutValid  output  1  downstream valid.
- dataOutStop  input  1  downstream stop.

Behaviour:
- SELF transfer rule: a transfer occurs in a cycle where valid=1 and stop=0. While valid=1 and stop=1, the sender holds data stable.
- State machine, two states:
  - EMPTY: no word held.
  - BUSY: word in shift register, beatCount = index of the current beat.
- Reset (srst=0, sampled on clk): state=EMPTY, beatCount=0, shift register cleared.
- Outputs during reset and in EMPTY:
  - dataInStop=1 during reset; dataInStop=0 in EMPTY out of reset.
  - dataOutValid=0, dataOutLast=0, dataOut=0.
- Reset mid-word: the held word is discarded, no further beats appear, and no partial-word recovery occurs.
- Clamp: lastIdx = min(dataInBeats, Ratio-1), captured at acceptance. Values above Ratio-1 are legal and are clamped.
- EMPTY with dataInValid=1 (dataInStop=0): capture dataIn and lastIdx, beatCount<=0, go to BUSY. The first beat is visible the next cycle (latency 1).
- BUSY outputs:
  - dataOutValid=1.
  - dataOut = shiftReg[DataOutWidth-1:0].
  - dataOutLast = (beatCount==lastIdx).
- BUSY with dataOutStop=1: hold all state; dataOut is stable.
- BUSY, beat consumed, not last: shiftReg >>= DataOutWidth, beatCount+1.
- BUSY, beat consumed, last beat:
  - If dataInValid=1: load the next word in the same cycle, beatCount<=0, stay in BUSY. There is no bubble.
  - Otherwise go to EMPTY.
- dataInStop in BUSY = NOT(beatCount==lastIdx AND dataOutStop==0).
  - This is a combinational path from dataOutStop to dataInStop.
  - It is permitted because the downstream elastic buffer registers its stop.
- dataOut, dataOutValid and dataOutLast are registered state. They have no combinational input-to-output path.
- dataOut bits above the remaining beats are don't-care but deterministic: zeros shifted in.
- Throughput: N+1 beats per word occupy exactly N+1 cycles when dataOutStop=0. This includes the N=0 single-beat case at one word per cycle.

Decomposition:
- Shared package self_link_pkg holds:
  - the state enum (SELF_EMPTY, SELF_BUSY);
  - a clog2 constant function;
  - the SELF transfer-condition macro or function.
- No sub-module. A single always block plus combinational stop logic is sufficient, roughly 150 lines.

Test Plan:
- Word transfer: DataOutWidth=8, Ratio=4; send dataIn=0x44332211, dataInBeats=3, dataOutStop=0 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles; dataOutLast only on 0x44; first beat one cycle after acceptance.
- Back-to-back words: 0x44332211 then 0x88776655, both beats=3, dataInValid held -> eight contiguous beats with no gap; dataInStop=0 only in the cycle 0x44 is consumed.
- Downstream stall: dataOutStop=1 for 3 cycles while 0x22 is presented -> 0x22 held stable; dataInStop=1 throughout; sequence resumes 0x22,0x33,0x44 with no loss or duplication.
- Short word and clamp:
  - beats=1 for 0xDDCCBBAA -> 0xAA, 0xBB(last), then EMPTY.
  - beats=0 -> single beat with dataOutLast=1.
  - Ratio=3 with beats=3 -> clamped to 3 beats.
- Reset mid-word: assert srst=0 after beat 0x22 -> next cycle dataOutValid=0, dataInStop=1. After release, dataInStop=0 and a fresh word starts at beat 0.
- Randomized valid/stop: toggle dataInValid and dataOutStop randomly -> a scoreboard shows every beat in order with correct last flags, and data stays stable while stalled.

Source files
------------

// File: rtl/self_link_pkg.sv
// -----------------------------------------------------------------------------
// self_link_pkg
// Shared definitions for SELF link blocks:
//   - self_state_e : two-state occupancy of a single-stage SELF holder
//   - self_clog2   : ceiling log2 usable in parameter expressions
//   - self_xfer    : SELF transfer condition (valid high, stop low)
// -----------------------------------------------------------------------------
package self_link_pkg;

  typedef enum logic {
    SELF_EMPTY = 1'b0,
    SELF_BUSY  = 1'b1
  } self_state_e;

  // Ceiling log2. Callers pass values >= 2, so the result is at least 1.
  function automatic int self_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A beat moves across a SELF link in any cycle with valid=1 and stop=0.
  function automatic logic self_xfer(input logic valid, input logic stop);
    return valid & ~stop;
  endfunction

endpackage

// File: rtl/self_link_width_splitter.sv
// -----------------------------------------------------------------------------
// self_link_width_splitter
// Accepts one wide word per SELF transfer and replays it as up to Ratio narrow
// beats, least-significant slice first, on a SELF output link. The number of
// beats per word is given by dataInBeats (beats minus one), clamped to Ratio-1.
// Back-to-back words stream at one beat per cycle with no bubble.
//
// Ports:
//   clk          in   rising-edge clock
//   srst         in   synchronous reset, active low
//   dataIn       in   wide word (DataOutWidth*Ratio bits)
//   dataInBeats  in   beats minus one for this word
//   dataInValid  in   upstream valid
//   dataInStop   out  upstream stop (combinational from dataOutStop)
//   dataOut      out  current narrow beat (registered)
//   dataOutLast  out  final beat of the word (registered)
//   dataOutValid out  downstream valid (registered)
//   dataOutStop  in   downstream stop
// -----------------------------------------------------------------------------
module self_link_width_splitter
  import self_link_pkg::*;
#(
  parameter int DataOutWidth = 16,
  parameter int Ratio        = 4,
  localparam int DataInWidth = DataOutWidth * Ratio,
  localparam int CountWidth  = self_clog2(Ratio)
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [DataInWidth-1:0]  dataIn,
  input  logic [CountWidth-1:0]   dataInBeats,
  input  logic                    dataInValid,
  output logic                    dataInStop,
  output logic [DataOutWidth-1:0] dataOut,
  output logic                    dataOutLast,
  output logic                    dataOutValid,
  input  logic                    dataOutStop
);

  localparam logic [CountWidth-1:0] MaxIdx = CountWidth'(Ratio - 1);

  self_state_e            state_q, state_d;
  logic [DataInWidth-1:0] shift_q, shift_d;
  logic [CountWidth-1:0]  beat_count_q, beat_count_d;
  logic [CountWidth-1:0]  last_idx_q, last_idx_d;
  logic                   last_q, last_d;

  logic [CountWidth-1:0]  clamped_beats;
  logic                   in_stop;
  logic                   load_word;
  logic                   beat_taken;

  // Beat counts beyond the word capacity are legal and saturate.
  always_comb begin
    clamped_beats = (dataInBeats > MaxIdx) ? MaxIdx : dataInBeats;
  end

  // Upstream may only hand over a word when nothing is held, or when the held
  // word's last beat leaves this very cycle (so the next word loads with no gap).
  always_comb begin
    in_stop = 1'b1;
    if (srst) begin
      if (state_q == SELF_EMPTY) begin
        in_stop = 1'b0;
      end else begin
        in_stop = ~(last_q & ~dataOutStop);
      end
    end
  end

  always_comb begin
    load_word  = self_xfer(dataInValid, in_stop);
    beat_taken = self_xfer(state_q == SELF_BUSY, dataOutStop);
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    beat_count_d = beat_count_q;
    last_idx_d   = last_idx_q;

    // In BUSY a load only happens alongside consumption of the last beat,
    // so it takes precedence over the shift/empty handling below.
    if (load_word) begin
      state_d      = SELF_BUSY;
      shift_d      = dataIn;
      beat_count_d = '0;
      last_idx_d   = clamped_beats;
    end else if (beat_taken) begin
      if (last_q) begin
        state_d      = SELF_EMPTY;
        shift_d      = '0;
        beat_count_d = '0;
        last_idx_d   = '0;
      end else begin
        shift_d      = shift_q >> DataOutWidth;
        beat_count_d = beat_count_q + CountWidth'(1);
      end
    end

    // Last flag is precomputed so dataOutLast comes straight from a flop.
    last_d = (state_d == SELF_BUSY) && (beat_count_d == last_idx_d);
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      state_q      <= SELF_EMPTY;
      shift_q      <= '0;
      beat_count_q <= '0;
      last_idx_q   <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      beat_count_q <= beat_count_d;
      last_idx_q   <= last_idx_d;
      last_q       <= last_d;
    end
  end

  assign dataInStop   = in_stop;
  assign dataOut      = shift_q[DataOutWidth-1:0];
  assign dataOutValid = (state_q == SELF_BUSY);
  assign dataOutLast  = last_q;

endmodule

// File: tb/tb_self_link_width_splitter.sv
module tb_self_link_width_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst;

  // Instance A: DataOutWidth=8, Ratio=4
  logic [31:0] a_din;
  logic [1:0]  a_beats;
  logic        a_vin, a_sin;
  logic [7:0]  a_dout;
  logic        a_last, a_vout, a_sout;

  // Instance B: DataOutWidth=8, Ratio=3 (exercises clamping)
  logic [23:0] b_din;
  logic [1:0]  b_beats;
  logic        b_vin, b_sin;
  logic [7:0]  b_dout;
  logic        b_last, b_vout, b_sout;

  self_link_width_splitter #(.DataOutWidth(8), .Ratio(4)) dut_a (
    .clk(clk), .srst(srst),
    .dataIn(a_din), .dataInBeats(a_beats), .dataInValid(a_vin), .dataInStop(a_sin),
    .dataOut(a_dout), .dataOutLast(a_last), .dataOutValid(a_vout), .dataOutStop(a_sout)
  );

  self_link_width_splitter #(.DataOutWidth(8), .Ratio(3)) dut_b (
    .clk(clk), .srst(srst),
    .dataIn(b_din), .dataInBeats(b_beats), .dataInValid(b_vin), .dataInStop(b_sin),
    .dataOut(b_dout), .dataOutLast(b_last), .dataOutValid(b_vout), .dataOutStop(b_sout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: beats accepted but not yet delivered, as {last, data}.
  logic [8:0] exp_q[$];
  // Log of delivered beats and acceptance cycles for directed checks.
  logic [8:0] obs_q[$];
  int         obs_cyc[$];
  int         acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle compare of instance A against the beat-queue model.
  always @(negedge clk) begin : monitor
    logic exp_valid;
    logic exp_sin;
    int   n;
    exp_valid = (exp_q.size() != 0);
    exp_sin   = !srst || !((exp_q.size() == 0) || (exp_q.size() == 1 && !a_sout));
    chk("a_in_stop", 32'(a_sin), 32'(exp_sin));
    chk("a_out_valid", 32'(a_vout), 32'(exp_valid));
    if (exp_valid) chk("a_beat", 32'({a_last, a_dout}), 32'(exp_q[0]));
    else           chk("a_idle_beat", 32'({a_last, a_dout}), 32'd0);
    if (!srst) begin
      exp_q.delete();
    end else begin
      if (a_vout && !a_sout) begin
        obs_q.push_back({a_last, a_dout});
        obs_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (a_vin && !a_sin) begin
        n = int'(a_beats) + 1;
        if (n > 4) n = 4;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), a_din[8*i +: 8]});
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    obs_q.delete();
    obs_cyc.delete();
    acc_cyc.delete();
  endtask

  // Presents a word and returns just after the edge that accepted it; valid stays high.
  task automatic send_a(input logic [31:0] d, input logic [1:0] b);
    a_din   = d;
    a_beats = b;
    a_vin   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!a_sin) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=stalled required=accepted");
  endtask

  task automatic chk_obs(input string name, input logic [8:0] req[$]);
    chk({name, "_count"}, 32'(obs_q.size()), 32'(req.size()));
    if (obs_q.size() == req.size()) begin
      foreach (req[i]) chk(name, 32'(obs_q[i]), 32'(req[i]));
    end
  endtask

  task automatic b_expect(input logic v, input logic l, input logic [7:0] d);
    @(negedge clk);
    chk("b_beat", 32'({b_vout, b_last, b_dout}), 32'({v, l, d}));
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [8:0] e[$];
    logic       took;

    srst = 1'b0;
    a_vin = 1'b0; a_din = '0; a_beats = '0; a_sout = 1'b0;
    b_vin = 1'b0; b_din = '0; b_beats = '0; b_sout = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_valid", 32'(a_vout), 32'd0);
    chk("reset_a_in_stop", 32'(a_sin), 32'd1);
    chk("reset_a_dout", 32'(a_dout), 32'd0);
    chk("reset_b_valid", 32'(b_vout), 32'd0);
    chk("reset_b_in_stop", 32'(b_sin), 32'd1);
    @(posedge clk);
    #1;
    srst = 1'b1;
    idle(2);

    // Clamp on Ratio=3: beats=3 must give 3 beats.
    b_din = 24'hCCBBAA; b_beats = 2'd3; b_vin = 1'b1;
    @(negedge clk);
    chk("b_accept_stop", 32'(b_sin), 32'd0);
    @(posedge clk);
    #1;
    b_vin = 1'b0;
    b_expect(1'b1, 1'b0, 8'hAA);
    b_expect(1'b1, 1'b0, 8'hBB);
    b_expect(1'b1, 1'b1, 8'hCC);
    b_expect(1'b0, 1'b0, 8'h00);
    b_din = 24'h332211; b_beats = 2'd1; b_vin = 1'b1;
    @(negedge clk);
    chk("b_accept_stop", 32'(b_sin), 32'd0);
    @(posedge clk);
    #1;
    b_vin = 1'b0;
    b_expect(1'b1, 1'b0, 8'h11);
    b_expect(1'b1, 1'b1, 8'h22);
    b_expect(1'b0, 1'b0, 8'h00);

    // Single word, latency and ordering.
    clear_log();
    send_a(32'h44332211, 2'd3);
    a_vin = 1'b0;
    idle(6);
    e = '{9'h011, 9'h022, 9'h033, 9'h144};
    chk_obs("word", e);
    if (obs_cyc.size() == 4 && acc_cyc.size() == 1) begin
      chk("word_latency", 32'(obs_cyc[0] - acc_cyc[0]), 32'd1);
      chk("word_contig", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);
    end

    // Back-to-back words with no bubble.
    clear_log();
    send_a(32'h44332211, 2'd3);
    send_a(32'h88776655, 2'd3);
    a_vin = 1'b0;
    idle(10);
    e = '{9'h011, 9'h022, 9'h033, 9'h144, 9'h055, 9'h066, 9'h077, 9'h188};
    chk_obs("b2b", e);
    if (obs_cyc.size() == 8 && acc_cyc.size() == 2) begin
      chk("b2b_contig", 32'(obs_cyc[7] - obs_cyc[0]), 32'd7);
      chk("b2b_accept_at_last", 32'(acc_cyc[1]), 32'(obs_cyc[3]));
    end

    // Downstream stall on the second beat.
    clear_log();
    send_a(32'h44332211, 2'd3);
    a_vin = 1'b0;
    idle(1);
    a_sout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'(a_dout), 32'h22);
      chk("stall_in_stop", 32'(a_sin), 32'd1);
      @(posedge clk);
      #1;
    end
    a_sout = 1'b0;
    idle(5);
    e = '{9'h011, 9'h022, 9'h033, 9'h144};
    chk_obs("stall", e);

    // Short words, including single-beat words at one per cycle.
    clear_log();
    send_a(32'hDDCCBBAA, 2'd1);
    a_vin = 1'b0;
    idle(4);
    e = '{9'h0AA, 9'h1BB};
    chk_obs("short", e);
    clear_log();
    send_a(32'h000000EE, 2'd0);
    send_a(32'h00000012, 2'd0);
    send_a(32'h00000034, 2'd0);
    a_vin = 1'b0;
    idle(4);
    e = '{9'h1EE, 9'h112, 9'h134};
    chk_obs("single", e);
    if (obs_cyc.size() == 3) chk("single_contig", 32'(obs_cyc[2] - obs_cyc[0]), 32'd2);

    // Reset in the middle of a word.
    clear_log();
    send_a(32'h44332211, 2'd3);
    a_vin = 1'b0;
    idle(2);
    srst = 1'b0;
    @(negedge clk);
    chk("rst_in_stop", 32'(a_sin), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 32'(a_vout), 32'd0);
    chk("rst_in_stop_held", 32'(a_sin), 32'd1);
    @(posedge clk);
    #1;
    srst = 1'b1;
    @(negedge clk);
    chk("rst_release_stop", 32'(a_sin), 32'd0);
    @(posedge clk);
    #1;
    e = '{9'h011, 9'h022};
    chk_obs("pre_rst", e);
    clear_log();
    send_a(32'h88776655, 2'd3);
    a_vin = 1'b0;
    idle(6);
    e = '{9'h055, 9'h066, 9'h077, 9'h188};
    chk_obs("post_rst", e);

    // Randomized valid/stop against the beat-queue model.
    clear_log();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      took = a_vin && !a_sin;
      @(posedge clk);
      #1;
      if (!a_vin || took) begin
        a_vin   = ($urandom_range(0, 3) != 0);
        a_din   = $urandom;
        a_beats = 2'($urandom);
      end
      a_sout = ($urandom_range(0, 2) == 0);
    end
    a_vin  = 1'b0;
    a_sout = 1'b0;
    idle(12);
    chk("random_drain", 32'(exp_q.size()), 32'd0);
    chk("random_activity", 32'(obs_q.size() > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
